// File: rtl/byte_mem_port.sv
// Byte-addressable 2^AW x 8 memory with a multi-byte big-endian request port and wrap-around lanes.
// Read latency 1 through a single-entry response buffer; the array is filled with INIT_VAL after reset or clr.
module byte_mem_port #(
    parameter int         BYTES    = 2,
    parameter int         AW       = 8,
    parameter logic [7:0] INIT_VAL = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_re,
    input  logic               req_we,
    input  logic [AW-1:0]      req_addr,
    input  logic [8*BYTES-1:0] req_wdata,
    input  logic [BYTES-1:0]   req_be,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [8*BYTES-1:0] rsp_rdata,
    output logic               init_done
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t             state;
    logic [AW-1:0]      init_cnt;
    logic [7:0]         mem [DEPTH];
    logic               accept;
    logic               do_clr;
    logic [8*BYTES-1:0] rd_word;

    // clr is honoured only with an empty response buffer, and it blocks a same-cycle request
    assign do_clr    = (state == S_RUN) && clr && !rsp_valid;
    assign req_ready = (state == S_RUN) && !do_clr && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign init_done = (state == S_RUN);

    // Lane k = 0 is the MSB lane at req_addr; higher lanes wrap modulo the array depth
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < BYTES; k++) begin
            rd_word[8*(BYTES-1-k) +: 8] = mem[req_addr + AW'(k)];
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[init_cnt] <= INIT_VAL;
        end else if (accept && req_we) begin
            for (int k = 0; k < BYTES; k++) begin
                if (req_be[BYTES-1-k]) begin
                    mem[req_addr + AW'(k)] <= req_wdata[8*(BYTES-1-k) +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_INIT;
            init_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + AW'(1);
                    if (&init_cnt) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (do_clr) begin
                        state    <= S_INIT;
                        init_cnt <= '0;
                    end
                    // rd_word samples the array before this cycle's write lands, giving swap semantics
                    if (accept && req_re) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rd_word;
                    end else if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: doc/byte_mem_port.md
BYTE_MEM_PORT -- requirements
Module: byte_mem_port

Interface
REQ-001 SHALL have parameter BYTES, default 2, bytes per access word (1..8).
REQ-002 SHALL have parameter AW, default 8, byte-address width; depth = 2^AW bytes.
REQ-003 SHALL have parameter INIT_VAL, default 8'h00, value written to every byte during initialisation.
REQ-004 SHALL have port clk  in  1  the single clock; all logic on posedge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port clr  in  1  synchronous request to re-initialise the whole array.
REQ-007 SHALL have port req_valid  in  1  request present.
REQ-008 SHALL have port req_ready  out  1  request accepted when req_valid && req_ready.
REQ-009 SHALL have port req_re  in  1  request reads.
REQ-010 SHALL have port req_we  in  1  request writes.
REQ-011 SHALL have port req_addr  in  AW  byte address of MSB lane.
REQ-012 SHALL have port req_wdata  in  8*BYTES  write data, big-endian.
REQ-013 SHALL have port req_be  in  BYTES  byte enables; bit BYTES-1 = MSB lane.
REQ-014 SHALL have port rsp_valid  out  1  read data held.
REQ-015 SHALL have port rsp_ready  in  1  consumer takes rsp_rdata when rsp_valid && rsp_ready.
REQ-016 SHALL have port rsp_rdata  out  8*BYTES  read data, big-endian.
REQ-017 SHALL have port init_done  out  1  high when array is initialised and requests are served.

Function
REQ-018 SHALL hold a 2^AW x 8-bit byte array; lane k (k=0 MSB) maps to byte address (req_addr+k) mod 2^AW, wrap-around included, no alignment restriction.
REQ-019 SHALL implement FSM states INIT and RUN; INIT entered from reset or from RUN when clr=1 and no response is held.
REQ-020 SHALL, in INIT, write INIT_VAL to one byte per cycle at address counter 0..2^AW-1, then go to RUN on the cycle after writing address 2^AW-1 (INIT lasts exactly 2^AW cycles).
REQ-021 SHALL drive req_ready=0 and init_done=0 throughout INIT; init_done=1 in RUN.
REQ-022 SHALL, in RUN, drive req_ready = !rsp_valid || rsp_ready (single-entry response buffer).
REQ-023 SHALL, on an accepted request with req_we=1, write req_wdata lane k to its byte address for every k with enable set; disabled lanes unchanged.
REQ-024 SHALL, on an accepted request with req_re=1, load rsp_rdata with pre-write array contents and set rsp_valid on the next cycle (latency 1).
REQ-025 SHALL, for req_re=1 and req_we=1 together, return old data and commit new data in the same cycle (swap).
REQ-026 SHALL treat accepted requests with req_re=0 and req_we=0 as no-ops; write-only requests produce no response.
REQ-027 SHALL hold rsp_valid and rsp_rdata stable while rsp_valid && !rsp_ready; clear rsp_valid on handshake unless a new read is accepted in the same cycle, in which case reload.
REQ-028 SHALL, when a read overlaps bytes written by the immediately preceding accepted write, return the newly written bytes.
REQ-029 SHALL ignore clr while rsp_valid=1 and during INIT; clr has priority over a simultaneous req_valid (request not accepted).

Reset
REQ-030 SHALL, on reset=0, immediately force state INIT, init counter 0, rsp_valid=0, rsp_rdata=0, req_ready=0, init_done=0.
REQ-031 SHALL, when reset asserts mid-INIT or mid-transaction, discard all in-flight state and restart INIT from address 0 after reset deasserts.
REQ-032 SHALL not rely on reset to clear the array; array contents are defined only by INIT.

Verification
REQ-033 SHALL verify: release reset -> init_done rises exactly 256 cycles later; read 8'hFF returns 16'h0000.
REQ-034 SHALL verify: write addr 8'h04 data 16'h1234 be 2'b11, then read 8'h04 -> rsp_rdata 16'h1234 one cycle after accept; read 8'h05 -> 16'h34xx with xx = 8'h00.
REQ-035 SHALL verify: write addr 8'hFF data 16'hDEAD -> m[FF]=DE, m[00]=AD; read 8'h00 -> 16'hAD00.
REQ-036 SHALL verify: write 16'hBEEF be 2'b01 at 8'h10 -> read 8'h10 returns 16'h00EF; then swap 16'h2BCD -> returns 16'h00EF, next read 16'h2BCD.
REQ-037 SHALL verify: rsp_ready held 0 for 5 cycles -> req_ready=0, rsp_rdata stable; rsp_ready=1 with new read same cycle -> back-to-back responses, no loss.
REQ-038 SHALL verify: clr pulse in RUN -> req_ready low 256 cycles, all bytes INIT_VAL; reset pulse mid-INIT at counter 100 -> INIT restarts at 0.
